// File: rtl/aes_tcdm_arb_wrap_if.sv
// TCDM-style request/response bundle of N parallel ports.
// The master side issues requests; the slave side grants them and returns responses.
interface aes_tcdm_arb_wrap_if #(
    parameter int unsigned N = 1
);
    logic [N-1:0]       req;
    logic [N-1:0]       wen;
    logic [N-1:0][31:0] add;
    logic [N-1:0][31:0] data;
    logic [N-1:0][3:0]  be;
    logic [N-1:0]       gnt;
    logic [N-1:0]       r_valid;
    logic [N-1:0][31:0] r_data;

    modport master (
        output req, wen, add, data, be,
        input  gnt, r_valid, r_data
    );

    modport slave (
        input  req, wen, add, data, be,
        output gnt, r_valid, r_data
    );
endinterface

// File: rtl/aes_tcdm_arb_wrap.sv
// Folds NCH engine TCDM channels onto MP master ports with per-port round-robin
// arbitration, stall locking, one-cycle response routing and performance counters.
module aes_tcdm_arb_wrap #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned MP    = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    aes_tcdm_arb_wrap_if.slave        chan,
    aes_tcdm_arb_wrap_if.master       tcdm,
    output logic [MP-1:0][CNT_W-1:0]  req_cnt_o,
    output logic [MP-1:0][CNT_W-1:0]  stall_cnt_o,
    output logic [MP-1:0]             err_o
);

    localparam int unsigned G  = NCH / MP;
    localparam int unsigned PW = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned GP = 1 << PW;
    localparam logic [PW:0] GV = (PW + 1)'(G);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if ((NCH < MP) || ((NCH % MP) != 0)) begin : g_param_check
        $error("aes_tcdm_arb_wrap: NCH must be a non-zero multiple of MP");
    end

    logic [MP-1:0][PW-1:0]    ptr_q, lock_sel_q, owner_q;
    logic [MP-1:0]            lock_q, pend_q, err_q;
    logic [MP-1:0][CNT_W-1:0] req_cnt_q, stall_cnt_q;

    logic [MP-1:0][PW-1:0]    sel, ptr_inc;
    logic [MP-1:0]            hs, stall;

    always_comb begin : arb_comb
        logic [GP-1:0] greq;
        logic          found;
        logic [PW:0]   idx;
        greq         = '0;
        found        = 1'b0;
        idx          = '0;
        sel          = '0;
        ptr_inc      = '0;
        hs           = '0;
        stall        = '0;
        tcdm.req     = '0;
        tcdm.wen     = '0;
        tcdm.add     = '0;
        tcdm.data    = '0;
        tcdm.be      = '0;
        chan.gnt     = '0;
        chan.r_valid = '0;
        chan.r_data  = '0;
        for (int p = 0; p < MP; p++) begin
            greq = '0;
            for (int k = 0; k < G; k++) begin
                greq[k] = chan.req[k*MP+p];
            end
            found = 1'b0;
            // A stalled selection keeps the port until it is granted or withdraws.
            if (lock_q[p] && greq[lock_sel_q[p]]) begin
                found  = 1'b1;
                sel[p] = lock_sel_q[p];
            end
            for (int j = 0; j < G; j++) begin
                idx = {1'b0, ptr_q[p]} + (PW + 1)'(j);
                if (idx >= GV) idx = idx - GV;
                if (!found && greq[idx[PW-1:0]]) begin
                    found  = 1'b1;
                    sel[p] = idx[PW-1:0];
                end
            end
            idx = {1'b0, sel[p]} + (PW + 1)'(1);
            if (idx >= GV) idx = '0;
            ptr_inc[p]  = idx[PW-1:0];
            hs[p]       = found & tcdm.gnt[p];
            stall[p]    = found & ~tcdm.gnt[p];
            tcdm.req[p] = found;
            for (int k = 0; k < G; k++) begin
                if (found && (sel[p] == PW'(k))) begin
                    tcdm.wen[p]       = chan.wen[k*MP+p];
                    tcdm.add[p]       = chan.add[k*MP+p];
                    tcdm.data[p]      = chan.data[k*MP+p];
                    tcdm.be[p]        = chan.be[k*MP+p];
                    chan.gnt[k*MP+p]  = tcdm.gnt[p];
                end
                if (tcdm.r_valid[p] && pend_q[p] && (owner_q[p] == PW'(k))) begin
                    chan.r_valid[k*MP+p] = 1'b1;
                    chan.r_data[k*MP+p]  = tcdm.r_data[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            lock_sel_q  <= '0;
            owner_q     <= '0;
            lock_q      <= '0;
            pend_q      <= '0;
            err_q       <= '0;
            req_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int p = 0; p < MP; p++) begin
                // Response tracking ignores clear so in-flight reads still land.
                pend_q[p] <= hs[p];
                if (hs[p]) owner_q[p] <= sel[p];
                if (clear_i) begin
                    ptr_q[p]       <= '0;
                    lock_q[p]      <= 1'b0;
                    lock_sel_q[p]  <= '0;
                    err_q[p]       <= 1'b0;
                    req_cnt_q[p]   <= '0;
                    stall_cnt_q[p] <= '0;
                end else begin
                    if (tcdm.r_valid[p] && !pend_q[p]) err_q[p] <= 1'b1;
                    if (hs[p]) begin
                        ptr_q[p]  <= ptr_inc[p];
                        lock_q[p] <= 1'b0;
                        if (req_cnt_q[p] != CNT_MAX) req_cnt_q[p] <= req_cnt_q[p] + 1'b1;
                    end else if (stall[p]) begin
                        lock_q[p]     <= 1'b1;
                        lock_sel_q[p] <= sel[p];
                        if (stall_cnt_q[p] != CNT_MAX) begin
                            stall_cnt_q[p] <= stall_cnt_q[p] + 1'b1;
                        end
                    end else begin
                        lock_q[p] <= 1'b0;
                    end
                end
            end
        end
    end

    assign req_cnt_o   = req_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule
